// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM encoding and digit helpers
// for the serial decimal adder/subtractor.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] nines(input logic [3:0] d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Single-digit BCD add / nine's-complement add
// with decimal adjust; purely combinational.
module bcd_digit_addsub
    import bcd_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       sub,
    input  logic       cin,
    output logic [3:0] sum_d,
    output logic       cout
);

    logic [3:0] bi;
    logic [4:0] t;
    logic [4:0] tadj;

    always_comb begin
        bi   = sub ? nines(b_d) : b_d;
        t    = {1'b0, a_d} + {1'b0, bi} + {4'b0, cin};
        tadj = t + {1'b0, BCD_ADJ};
        if (t > {1'b0, BCD_MAX}) begin
            sum_d = tadj[3:0];
            cout  = 1'b1;
        end else begin
            sum_d = t[3:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_addsub_serial.sv
// N-digit BCD adder/subtractor, one digit per clock,
// LSD first, with start/busy/done handshake.
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      sub,
    input  logic [BCD_W*DIGITS-1:0]   a,
    input  logic [BCD_W*DIGITS-1:0]   b,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   result,
    output logic                      cout,
    output logic                      err
);

    localparam int W  = BCD_W * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic          sub_r;
    logic          err_r;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  shadow;
    logic [W-1:0]  shadow_nx;
    logic [3:0]    a_d;
    logic [3:0]    b_d;
    logic [3:0]    sum_d;
    logic          c_nx;
    logic          bad;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[i*BCD_W +: BCD_W] > BCD_MAX ||
                b[i*BCD_W +: BCD_W] > BCD_MAX)
                bad = 1'b1;
        end
    end

    // Select the active digit and merge its sum into the shadow copy
    always_comb begin
        a_d       = '0;
        b_d       = '0;
        shadow_nx = shadow;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                a_d = a_r[i*BCD_W +: BCD_W];
                b_d = b_r[i*BCD_W +: BCD_W];
                shadow_nx[i*BCD_W +: BCD_W] = sum_d;
            end
        end
    end

    bcd_digit_addsub u_dig (
        .a_d   (a_d),
        .b_d   (b_d),
        .sub   (sub_r),
        .cin   (carry),
        .sum_d (sum_d),
        .cout  (c_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            sub_r  <= 1'b0;
            err_r  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            shadow <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        a_r   <= a;
                        b_r   <= b;
                        sub_r <= sub;
                        idx   <= '0;
                        carry <= sub;
                        err_r <= bad;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    carry  <= c_nx;
                    shadow <= shadow_nx;
                    if (idx == LAST) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        err    <= err_r;
                        result <= err_r ? '0 : shadow_nx;
                        // a final carry of 0 on subtract means a borrow
                        cout   <= err_r ? 1'b0 : (sub_r ? ~c_nx : c_nx);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bcd_addsub_serial.md
# bcd_addsub_serial

Parametrised N-digit BCD adder/subtractor that processes one decimal digit per clock, least-significant digit first, behind a start/busy/done handshake. It is the multi-digit, sequential successor to the single-digit BCD adder. The clock datapath uses it for time arithmetic such as alarm offsets, countdown and time-difference display. Subtraction uses ten's-complement arithmetic, so results wrap modulo 10^DIGITS, matching counter wrap-around elsewhere in the clock.

## Interface
- DIGITS, default 4: number of BCD digits per operand; legal range 1..8.
- clk  in  1: system clock, rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: request; sampled only when state is IDLE or DONE.
- sub  in  1: 0 = a+b, 1 = a−b; latched with start.
- a  in  4*DIGITS: operand A, packed BCD, digit 0 in bits [3:0].
- b  in  4*DIGITS: operand B, same packing.
- busy  out  1: high while in CALC.
- done  out  1: one-cycle pulse; result, cout and err are valid from this cycle onward.
- result  out  4*DIGITS: packed BCD result, held until the next done.
- cout  out  1: add = decimal carry out of the MSD; sub = borrow (1 when a<b).
- err  out  1: an input digit was >9 at start; held like result.

## Operation
- States:
  - IDLE: entered at reset.
  - CALC: processes one digit per cycle.
  - DONE: one cycle long.
- Transitions:
  - IDLE or DONE with start=1 → CALC. On the same edge, latch a, b and sub; clear the digit index; set the carry register to sub (1 for subtract, 0 for add); compute and latch err.
  - DONE with start=0 → IDLE.
  - CALC with index = DIGITS−1 → DONE. Otherwise stay in CALC and increment the index.
- start while in CALC is ignored, not queued.
- Per-digit step for digit i:
  - Operand: bi = b_i for add, 9−b_i for subtract (nine's complement).
  - Sum: t = a_i + bi + c, 5 bits wide.
  - Adjust: if t>9, digit = (t+6)[3:0] and c=1; otherwise digit = t[3:0] and c=0.
- Final carry:
  - Add: cout = c.
  - Subtract: cout = ~c. When a borrow occurs, result holds the ten's complement, i.e. a−b+10^DIGITS.
- Digits are accumulated in an internal shadow register. result, cout and err update only on the CALC→DONE edge, so result never shows partial values.
- Invalid input: if any digit of a or b is >9 at start, err=1. The operation still takes the normal latency, but result is forced to 0 and cout to 0.
- Reset behaviour:
  - rst has priority over everything, including mid-operation. It returns the block to IDLE with no done pulse.
  - Reset values: busy=0, done=0, result=0, cout=0, err=0. Index, carry and the shadow register are also cleared.

## Timing
- Let T0 be the edge where start is accepted.
- busy=1 in the cycles following edges T0 through T0+DIGITS−1, i.e. exactly DIGITS cycles.
- Digit i is written at edge T0+1+i.
- done=1 for the single cycle after edge T0+DIGITS; busy=0 in that cycle.
- Latency from start edge to done cycle is DIGITS cycles.
- Back-to-back operation: start asserted during the DONE cycle is accepted, giving a throughput of one operation per DIGITS+1 cycles.
- result, cout and err are stable from the done cycle until the next done, or until reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package bcd_pkg holds:
  - BCD_W = 4, BCD_MAX = 4'd9, BCD_ADJ = 4'd6.
  - State encoding (IDLE, CALC, DONE).
  - A function returning the nine's complement of a digit.
- Sub-module bcd_digit_addsub is purely combinational:
  - Inputs: a_d, b_d, sub, cin.
  - Outputs: sum_d, cout.
  - The top level instantiates it once and multiplexes digit i into it using the index.
- Top level contains the FSM, index counter, carry register, operand registers, shadow register and output registers.
- Expected size is roughly 150–250 lines total.

## Test plan
- Add with full carry: DIGITS=4, a=0x1234, b=0x8766, sub=0 → done 4 cycles after start, result=0x0000, cout=1, err=0.
- Subtract, no borrow: a=0x1000, b=0x0001, sub=1 → result=0x0999, cout=0.
- Subtract with borrow and wrap: a=0x0000, b=0x0001, sub=1 → result=0x9999, cout=1.
- Invalid digit: a=0x12A4, b=0x0001 → err=1, result=0x0000, cout=0, done after the normal 4 cycles.
- Handshake and reset:
  - start held high during CALC is ignored.
  - start in the DONE cycle is accepted, so the next done arrives 5 cycles after the previous one.
  - rst asserted at digit 2 → next cycle busy=0, done=0, result=0, and no done pulse follows.
- Parameter sweep: DIGITS=1 and DIGITS=8 against a random reference model (2000 vectors each) → bit-exact result and cout, latency = DIGITS.
